serial_add_ctrl: RTL and testbench

//  Bit-serial adder sequencer: time-shares one full_adder cell across WIDTH cycles
//  to add two WIDTH-bit operands plus carry-in, LSB first, with a registered carry.

---
 rtl/serial_add_ctrl.sv | 82 ++++++++
 tb/tb_serial_add_ctrl.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial adder sequencer; start/A/B/C0 in, busy/done/S/C out, one full-adder cell reused over WIDTH cycles
module serial_add_ctrl #(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             C0,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] S,
  output logic             C
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state_q, state_d;
  logic [WIDTH-1:0] opa_q, opa_d, opb_q, opb_d, acc_q, acc_d, s_q, s_d, acc_nx;
  logic [CW-1:0] cnt_q, cnt_d;
  logic carry_q, carry_d, c_q, c_d, sum_bit, cout_bit, last;
  assign sum_bit  = opa_q[0] ^ opb_q[0] ^ carry_q;
  assign cout_bit = (opa_q[0] & opb_q[0]) | (carry_q & (opa_q[0] ^ opb_q[0]));
  assign acc_nx   = (acc_q >> 1) | (WIDTH'(sum_bit) << (WIDTH - 1));
  assign last     = cnt_q == CW'(WIDTH - 1);
  always_comb begin
    state_d = state_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    acc_d   = acc_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    s_d     = s_q;
    c_d     = c_q;
    if (state_q == RUN) begin
      carry_d = cout_bit;
      acc_d   = acc_nx;
      opa_d   = opa_q >> 1;
      opb_d   = opb_q >> 1;
      cnt_d   = cnt_q + CW'(1);
      if (last) begin
        s_d     = acc_nx;
        c_d     = cout_bit;
        state_d = DONE;
      end
    end else if (start) begin
      opa_d   = A;
      opb_d   = B;
      carry_d = C0;
      acc_d   = '0;
      cnt_d   = '0;
      state_d = RUN;
    end else begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      opa_q   <= '0;
      opb_q   <= '0;
      acc_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      s_q     <= '0;
      c_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      acc_q   <= acc_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      s_q     <= s_d;
      c_q     <= c_d;
    end
  end
  assign busy = state_q == RUN;
  assign done = state_q == DONE;
  assign S    = s_q;
  assign C    = c_q;
endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb_serial_add_ctrl: randomized and directed checks of serial_add_ctrl at WIDTH 3, 8 and 1 against A+B+C0
module tb_serial_add_ctrl;
  logic clk = 1'b0;
  logic rst;
  logic [2:0] st;
  logic [7:0] a_in, b_in;
  logic c_in;
  logic [2:0] busy_o, done_o, c_o;
  logic [2:0] s3;
  logic [7:0] s8;
  logic s1;
  int checks = 0, failures = 0;
  logic [7:0] exp_s [3];
  logic exp_c [3];
  int wd [3] = '{3, 8, 1};
  always #5 clk = ~clk;
  serial_add_ctrl #(.WIDTH(3)) u3 (.clk(clk), .rst(rst), .start(st[0]), .A(a_in[2:0]), .B(b_in[2:0]), .C0(c_in),
    .busy(busy_o[0]), .done(done_o[0]), .S(s3), .C(c_o[0]));
  serial_add_ctrl #(.WIDTH(8)) u8 (.clk(clk), .rst(rst), .start(st[1]), .A(a_in), .B(b_in), .C0(c_in),
    .busy(busy_o[1]), .done(done_o[1]), .S(s8), .C(c_o[1]));
  serial_add_ctrl #(.WIDTH(1)) u1 (.clk(clk), .rst(rst), .start(st[2]), .A(a_in[0]), .B(b_in[0]), .C0(c_in),
    .busy(busy_o[2]), .done(done_o[2]), .S(s1), .C(c_o[2]));
  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  function automatic logic [7:0] s_of(int k);
    return k == 0 ? {5'b0, s3} : k == 1 ? s8 : {7'b0, s1};
  endfunction
  task automatic hold_chk(int k, string tag);
    chk({tag, "_S"}, s_of(k), exp_s[k]);
    chk({tag, "_C"}, c_o[k], exp_c[k]);
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic add(int k, logic [7:0] a, logic [7:0] b, logic c0, bit chaos);
    int w;
    logic [7:0] m;
    logic [8:0] sum;
    w = wd[k];
    m = 8'((9'd1 << w) - 9'd1);
    a = a & m;
    b = b & m;
    sum = {1'b0, a} + {1'b0, b} + {8'b0, c0};
    a_in = a;
    b_in = b;
    c_in = c0;
    st[k] = 1'b1;
    step;
    for (int i = 0; i < w; i++) begin
      chk("run_busy", busy_o[k], 1);
      chk("run_done", done_o[k], 0);
      hold_chk(k, "run_hold");
      if (chaos) begin
        a_in = 8'($urandom);
        b_in = 8'($urandom);
        c_in = 1'($urandom);
      end else st[k] = 1'b0;
      step;
    end
    exp_s[k] = sum[7:0] & m;
    exp_c[k] = sum[w];
    chk("res_done", done_o[k], 1);
    chk("res_busy", busy_o[k], 0);
    hold_chk(k, "res");
  endtask
  task automatic idle(int n);
    st = '0;
    repeat (n) begin
      step;
      for (int j = 0; j < 3; j++) begin
        chk("idle_done", done_o[j], 0);
        chk("idle_busy", busy_o[j], 0);
        hold_chk(j, "idle");
      end
    end
  endtask
  initial begin
    rst = 1'b1;
    st = '0;
    a_in = '0;
    b_in = '0;
    c_in = 1'b0;
    for (int j = 0; j < 3; j++) begin
      exp_s[j] = '0;
      exp_c[j] = 1'b0;
    end
    step;
    step;
    rst = 1'b0;
    for (int j = 0; j < 3; j++) begin
      chk("rst_busy", busy_o[j], 0);
      chk("rst_done", done_o[j], 0);
      chk("rst_S", s_of(j), 0);
      chk("rst_C", c_o[j], 0);
    end
    add(0, 8'd3, 8'd5, 1'b0, 1'b0);
    chk("t1_S", s3, 3'b000);
    chk("t1_C", c_o[0], 1);
    idle(2);
    add(0, 8'd7, 8'd7, 1'b1, 1'b0);
    chk("t2a_S", s3, 3'b111);
    chk("t2a_C", c_o[0], 1);
    idle(1);
    add(0, 8'd0, 8'd0, 1'b0, 1'b0);
    chk("t2b_S", s3, 3'b000);
    chk("t2b_C", c_o[0], 0);
    idle(1);
    add(0, 8'd5, 8'd6, 1'b1, 1'b1);
    add(0, 8'd2, 8'd3, 1'b0, 1'b1);
    add(0, 8'd7, 8'd1, 1'b0, 1'b0);
    idle(2);
    a_in = 8'd6;
    b_in = 8'd7;
    c_in = 1'b1;
    st[0] = 1'b1;
    step;
    st[0] = 1'b0;
    step;
    rst = 1'b1;
    step;
    rst = 1'b0;
    for (int j = 0; j < 3; j++) begin
      exp_s[j] = '0;
      exp_c[j] = 1'b0;
      chk("mid_rst_busy", busy_o[j], 0);
      chk("mid_rst_done", done_o[j], 0);
      chk("mid_rst_S", s_of(j), 0);
      chk("mid_rst_C", c_o[j], 0);
    end
    idle(1);
    add(0, 8'd4, 8'd4, 1'b1, 1'b0);
    idle(1);
    for (int c = 0; c < 2; c++)
      for (int a = 0; a < 8; a++)
        for (int b = 0; b < 8; b++) begin
          add(0, 8'(a), 8'(b), 1'(c), 1'b0);
          if ((a + b) % 3 == 0) idle(1);
        end
    idle(1);
    for (int n = 0; n < 500; n++) begin
      add(1, 8'($urandom), 8'($urandom), 1'($urandom), $urandom_range(0, 3) == 0);
      if ($urandom_range(0, 1) == 0) idle(1);
    end
    idle(1);
    add(2, 8'd1, 8'd1, 1'b1, 1'b0);
    chk("w1_S", s1, 1);
    chk("w1_C", c_o[2], 1);
    idle(1);
    for (int n = 0; n < 8; n++) begin
      add(2, 8'($urandom), 8'($urandom), 1'($urandom), 1'b0);
      if (n % 2 == 0) idle(1);
    end
    idle(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
